// File: rtl/tone_seq_pkg.sv
// Shared definitions for the poly tone sequencer: voice FSM encodings, note-entry layout, 7-seg.
// Optional build macro: NOTE_GAP_EN (adds a one-ms silent gap after every note).
package tone_seq_pkg;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StPlay = 3'd2;
    localparam logic [2:0] StGap  = 3'd3;
    localparam logic [2:0] StFin  = 3'd4;

    // Entry layout is {half_period, dur_ms}; duration sits in the low bits.
    localparam int unsigned DurLsb = 0;

    // Segment order gfedcba, high = lit.
    function automatic logic [6:0] seg7(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: note table, sequencing FSM, half-period and duration counters.
// NOTE_GAP_EN defined: a one-ms silent GAP state follows every note before the next LOAD.
module tone_voice
    import tone_seq_pkg::*;
#(
    parameter int unsigned NOTE_DEPTH = 32,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DUR_W      = 8,
    parameter int unsigned AW         = $clog2(NOTE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ms_tick,
    input  logic                   go,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic                   all_fin,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DIV_W+DUR_W-1:0] wr_data,
    output logic                   sound,
    output logic                   active,
    output logic                   fin,
    output logic [3:0]             idx_nib
);

    localparam int unsigned EW = DIV_W + DUR_W;
    localparam logic [AW-1:0] LastIdx = AW'(NOTE_DEPTH - 1);
`ifdef NOTE_GAP_EN
    localparam logic [2:0] AfterNote = StGap;
`else
    localparam logic [2:0] AfterNote = StLoad;
`endif

    logic [EW-1:0]    table_q [NOTE_DEPTH];
    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             snd_q, snd_d;
    logic [EW-1:0]    entry;
    logic [DIV_W-1:0] entry_hp;
    logic [DUR_W-1:0] entry_dur;
    logic             note_end;

    // Table is deliberately not reset so songs survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign entry     = table_q[idx_q];
    assign entry_dur = entry[DurLsb +: DUR_W];
    assign entry_hp  = entry[EW-1:DUR_W];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hp_d     = hp_q;
        hp_cnt_d = hp_cnt_q;
        dur_d    = dur_q;
        snd_d    = snd_q;
        note_end = 1'b0;
        if (stop) begin
            state_d = StIdle;
            snd_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go) begin
                        state_d = StLoad;
                        idx_d   = '0;
                    end
                end
                StLoad: begin
                    if (entry_dur == '0) begin
                        if (loop_en) begin
                            idx_d = '0;
                        end else begin
                            state_d = StFin;
                        end
                    end else begin
                        state_d  = StPlay;
                        hp_d     = entry_hp;
                        dur_d    = entry_dur;
                        hp_cnt_d = '0;
                        snd_d    = 1'b0;
                    end
                end
                StPlay: begin
                    if (hp_q != '0) begin
                        if (hp_cnt_q == hp_q - 1'b1) begin
                            hp_cnt_d = '0;
                            snd_d    = ~snd_q;
                        end else begin
                            hp_cnt_d = hp_cnt_q + 1'b1;
                        end
                    end
                    if (ms_tick) begin
                        dur_d    = dur_q - 1'b1;
                        note_end = (dur_q == DUR_W'(1));
                    end
                    if (note_end) begin
                        snd_d = 1'b0;
                        // The last table slot behaves like an end marker after it plays.
                        if (idx_q == LastIdx) begin
                            if (loop_en) begin
                                idx_d   = '0;
                                state_d = AfterNote;
                            end else begin
                                state_d = StFin;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = AfterNote;
                        end
                    end
                end
`ifdef NOTE_GAP_EN
                StGap: begin
                    if (ms_tick) begin
                        state_d = StLoad;
                    end
                end
`endif
                StFin: begin
                    if (all_fin) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            hp_q     <= '0;
            hp_cnt_q <= '0;
            dur_q    <= '0;
            snd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hp_q     <= hp_d;
            hp_cnt_q <= hp_cnt_d;
            dur_q    <= dur_d;
            snd_q    <= snd_d;
        end
    end

    assign sound   = snd_q;
    assign active  = (state_q != StIdle);
    assign fin     = (state_q == StFin);
    assign idx_nib = 4'(idx_q);

endmodule

// File: rtl/poly_tone_sequencer.sv
// Multi-voice tone sequencer top: ms tick generator, table write decode, busy/done, led, mix.
// Optional build macro: NOTE_GAP_EN (forwarded to every tone_voice).
module poly_tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned NOTE_DEPTH = 32,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DUR_W      = 8,
    parameter int unsigned AW         = $clog2(NOTE_DEPTH),
    parameter int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            ticks_per_milli,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic                   wr_en,
    input  logic [VW-1:0]          wr_voice,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DIV_W+DUR_W-1:0] wr_data,
    output logic                   wr_ready,
    output logic [NUM_VOICES-1:0]  sound,
    output logic                   mix,
    output logic [7:0]             led,
    output logic                   busy,
    output logic                   done
);

    logic [15:0]           cnt_q, cnt_d, tick_max;
    logic                  ms_tick;
    logic [NUM_VOICES-1:0] active, fin;
    logic [3:0]            nib [NUM_VOICES];
    logic                  all_fin, go, done_q;

    // >= compare means lowering ticks_per_milli below the count ticks at once instead of wrapping.
    always_comb begin
        tick_max = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
        ms_tick  = (cnt_q >= tick_max);
        cnt_d    = ms_tick ? 16'd0 : cnt_q + 16'd1;
    end

    assign busy    = |active;
    assign all_fin = &fin;
    assign go      = start & ~stop & ~busy;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .NOTE_DEPTH (NOTE_DEPTH),
            .DIV_W      (DIV_W),
            .DUR_W      (DUR_W),
            .AW         (AW)
        ) u_voice (
            .clk     (clk),
            .rst_n   (rst_n),
            .ms_tick (ms_tick),
            .go      (go),
            .stop    (stop),
            .loop_en (loop_en),
            .all_fin (all_fin),
            .wr_en   (wr_en & ~busy & (wr_voice == VW'(v))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .sound   (sound[v]),
            .active  (active[v]),
            .fin     (fin[v]),
            .idx_nib (nib[v])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 16'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= all_fin & ~stop;
        end
    end

    assign done     = done_q;
    assign wr_ready = ~busy;
    assign mix      = |sound;
    assign led      = busy ? {1'b1, seg7(nib[0])} : 8'h00;

endmodule

// File: tb/tb_poly_tone_sequencer.sv
// Self-checking bench for poly_tone_sequencer: cycle reference model, vector table, corner cases.
module tb_poly_tone_sequencer;

    localparam int NV = 2;
    localparam int ND = 32;
    localparam int AW = 5;
    localparam int RW = 8;
    localparam int EW = 24;
`ifdef NOTE_GAP_EN
    localparam int GapEn = 1;
`else
    localparam int GapEn = 0;
`endif
    localparam int MIdle = 0, MLoad = 1, MPlay = 2, MGap = 3, MFin = 4;
    localparam logic [6:0] Seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   tpm;
    logic          start, stop, loop_en, wr_en;
    logic [0:0]    wr_voice;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic          wr_ready, mix, busy, done;
    logic [NV-1:0] sound;
    logic [7:0]    led;

    always #5 clk = ~clk;

    poly_tone_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (tpm),
        .start           (start),
        .stop            (stop),
        .loop_en         (loop_en),
        .wr_en           (wr_en),
        .wr_voice        (wr_voice),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .sound           (sound),
        .mix             (mix),
        .led             (led),
        .busy            (busy),
        .done            (done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: voice phase, note index, elapsed clocks in note, ms left in note.
    int m_st [NV];
    int m_idx [NV];
    int m_hp [NV];
    int m_left [NV];
    int m_el [NV];
    int m_thp [NV][ND];
    int m_tdur [NV][ND];
    int m_cnt;
    bit m_done;

    function automatic bit model_busy();
        bit b = 0;
        for (int v = 0; v < NV; v++) if (m_st[v] != MIdle) b = 1;
        return b;
    endfunction

    task automatic model_step();
        bit tick, mb, mf;
        int eff;
        eff = (tpm == 16'd0) ? 1 : int'(tpm);
        tick = (m_cnt >= eff - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        mb = model_busy();
        mf = 1;
        for (int v = 0; v < NV; v++) if (m_st[v] != MFin) mf = 0;
        m_done = mf && !stop;
        if (wr_en && !mb) begin
            m_thp[wr_voice][wr_addr]  = int'(wr_data[EW-1:RW]);
            m_tdur[wr_voice][wr_addr] = int'(wr_data[RW-1:0]);
        end
        for (int v = 0; v < NV; v++) begin
            if (stop) begin
                m_st[v] = MIdle;
            end else begin
                case (m_st[v])
                    MIdle: if (start && !mb) begin m_st[v] = MLoad; m_idx[v] = 0; end
                    MLoad: begin
                        if (m_tdur[v][m_idx[v]] == 0) begin
                            if (loop_en) m_idx[v] = 0;
                            else m_st[v] = MFin;
                        end else begin
                            m_st[v]   = MPlay;
                            m_hp[v]   = m_thp[v][m_idx[v]];
                            m_left[v] = m_tdur[v][m_idx[v]];
                            m_el[v]   = 0;
                        end
                    end
                    MPlay: begin
                        m_el[v]++;
                        if (tick) m_left[v]--;
                        if (m_left[v] == 0) begin
                            if (m_idx[v] == ND - 1 && !loop_en) begin
                                m_st[v] = MFin;
                            end else begin
                                m_idx[v] = (m_idx[v] == ND - 1) ? 0 : m_idx[v] + 1;
                                m_st[v]  = GapEn ? MGap : MLoad;
                            end
                        end
                    end
                    MGap: if (tick) m_st[v] = MLoad;
                    default: if (mf) m_st[v] = MIdle;
                endcase
            end
        end
    endtask

    task automatic check(input string tag);
        logic [NV-1:0] es;
        logic          eb;
        logic [7:0]    el;
        for (int v = 0; v < NV; v++)
            es[v] = (m_st[v] == MPlay) && (m_hp[v] != 0) && (((m_el[v] / m_hp[v]) % 2) == 1);
        eb = model_busy();
        el = eb ? {1'b1, Seg[m_idx[0] % 16]} : 8'h00;
        n_vec++;
        if (sound !== es || mix !== (|es) || busy !== eb || done !== m_done ||
            wr_ready !== !eb || led !== el) begin
            n_bad++;
            $display("FAIL %s @%0t: got snd=%b mix=%b busy=%b done=%b rdy=%b led=%h; want snd=%b mix=%b busy=%b done=%b rdy=%b led=%h",
                     tag, $time, sound, mix, busy, done, wr_ready, led,
                     es, |es, eb, m_done, !eb, el);
        end
    endtask

    task automatic cmp(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic wr(input int v, input int a, input int hp, input int dur);
        wr_en    = 1'b1;
        wr_voice = 1'(v);
        wr_addr  = AW'(a);
        wr_data  = {16'(hp), 8'(dur)};
        step("write");
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step("start");
        start = 1'b0;
    endtask

    // Steps until the model is idle; returns cycles taken and done pulses seen on the DUT.
    task automatic run_idle(input string tag, input int budget, output int cyc, output int dones);
        cyc = 0;
        dones = 0;
        do begin
            step(tag);
            cyc++;
            if (done) dones++;
        end while (model_busy() && cyc < budget);
        if (model_busy()) cmp({tag, " timeout"}, cyc, -1);
    endtask

    typedef struct {
        int tpm;
        int hp;
        int dur;
        int done_at;
        int highs;
    } vec_t;

    vec_t vt [6];
    int   cyc, dones, got, highs;

    initial begin
        vt[0] = '{1, 1, 4, 7, 2};
        vt[1] = '{0, 3, 8, 11, 3};
        vt[2] = '{1, 0, 5, 8, 0};
        vt[3] = '{0, 2, 7, 10, 3};
        vt[4] = '{1, 5, 3, 6, 0};
        vt[5] = '{0, 1, 1, 4, 0};

        rst_n = 1'b0; tpm = 16'd4; start = 0; stop = 0; loop_en = 0; wr_en = 0;
        wr_voice = '0; wr_addr = '0; wr_data = '0;
        for (int v = 0; v < NV; v++) begin
            m_st[v] = MIdle; m_idx[v] = 0; m_hp[v] = 0; m_left[v] = 0; m_el[v] = 0;
            for (int a = 0; a < ND; a++) begin m_thp[v][a] = 0; m_tdur[v][a] = 0; end
        end
        m_cnt = 0; m_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset");
        cmp("reset wr_ready", int'(wr_ready), 1);
        rst_n = 1'b1;

        // Single-note vectors with a tick every clock: done timing and tone high count.
        foreach (vt[i]) begin
            tpm = 16'(vt[i].tpm);
            wr(0, 0, vt[i].hp, vt[i].dur);
            wr(0, 1, 0, 0);
            wr(1, 0, 0, 0);
            pulse_start();
            got = -1; highs = 0;
            for (int n = 1; n <= 40; n++) begin
                step("vec");
                if (sound[0]) highs++;
                if (done) begin got = n; break; end
            end
            cmp($sformatf("vec%0d done_at", i), got, vt[i].done_at + GapEn);
            cmp($sformatf("vec%0d highs", i), highs, vt[i].highs);
        end

        // ticks=4 single note, then two voices with a rest: one done only after both finish.
        tpm = 16'd4;
        wr(0, 0, 3, 2); wr(0, 1, 0, 0); wr(1, 0, 0, 0);
        pulse_start();
        run_idle("t1", 100, cyc, dones);
        cmp("t1 dones", dones, 1);
        tpm = 16'd3;
        wr(0, 0, 5, 1); wr(0, 1, 0, 3); wr(0, 2, 0, 0); wr(1, 0, 2, 4); wr(1, 1, 0, 0);
        pulse_start();
        run_idle("t2", 200, cyc, dones);
        cmp("t2 dones", dones, 1);

        // Looping song never finishes; stop clears everything on the next clock.
        tpm = 16'd1; loop_en = 1'b1;
        wr(0, 0, 2, 2); wr(0, 1, 3, 1); wr(0, 2, 0, 0); wr(1, 0, 1, 3); wr(1, 1, 0, 0);
        pulse_start();
        dones = 0;
        for (int n = 0; n < 40; n++) begin step("loop"); if (done) dones++; end
        cmp("loop no done", dones, 0);
        cmp("loop busy", int'(busy), 1);
        stop = 1'b1; step("stop"); stop = 1'b0; loop_en = 1'b0;
        cmp("stop sound", int'(sound), 0);
        cmp("stop busy", int'(busy), 0);
        cmp("stop done", int'(done), 0);
        start = 1'b1; stop = 1'b1; step("stop beats start"); start = 1'b0; stop = 1'b0;
        cmp("stop beats start", int'(busy), 0);

        // Drop ticks_per_milli from 100 to 3 while the count sits at 50.
        tpm = 16'd100;
        wr(0, 0, 7, 2); wr(0, 1, 0, 0); wr(1, 0, 0, 0);
        pulse_start();
        for (int n = 0; n < 400; n++) begin
            if (m_st[0] == MPlay && m_left[0] == 1 && m_cnt == 50) break;
            step("tpm wait");
        end
        cmp("tpm reach cnt50", m_cnt, 50);
        tpm = 16'd3;
        got = -1;
        for (int n = 1; n <= 12; n++) begin step("tpm drop"); if (done) begin got = n; break; end end
        cmp("tpm drop done_at", got, GapEn ? 6 : 3);

        // Writes during playback are dropped; the replay keeps the original timing.
        tpm = 16'd1;
        wr(0, 0, 2, 3); wr(0, 1, 0, 0); wr(1, 0, 0, 0);
        pulse_start();
        wr_en = 1'b1; wr_voice = 1'b0; wr_addr = '0; wr_data = {16'd1, 8'd9};
        step("wr busy");
        cmp("wr_ready busy", int'(wr_ready), 0);
        run_idle("wr busy", 50, cyc, dones);
        wr_en = 1'b0;
        pulse_start();
        got = -1;
        for (int n = 1; n <= 30; n++) begin step("replay"); if (done) begin got = n; break; end end
        cmp("replay done_at", got, 6 + GapEn);

        // Every slot holds a note: the last slot ends the song.
        for (int a = 0; a < ND; a++) wr(0, a, 1, 1);
        wr(1, 0, 0, 0);
        pulse_start();
        got = -1;
        for (int n = 1; n <= 120; n++) begin step("full"); if (done) begin got = n; break; end end
        cmp("full table done_at", got, 65 + 31 * GapEn);

        // Randomised songs, stray starts and writes while busy, occasional stop.
        for (int it = 0; it < 30; it++) begin
            int nn, cyc_r;
            tpm = 16'($urandom_range(0, 4));
            loop_en = ($urandom_range(0, 3) == 0);
            for (int v = 0; v < NV; v++) begin
                nn = $urandom_range(0, 3);
                for (int a = 0; a < nn; a++) wr(v, a, $urandom_range(0, 4), $urandom_range(1, 3));
                wr(v, nn, 0, 0);
            end
            pulse_start();
            cyc_r = 0;
            while (model_busy() && cyc_r < 200) begin
                if ($urandom_range(0, 9) == 0) start = 1'b1;
                if ($urandom_range(0, 4) == 0) begin
                    wr_en = 1'b1; wr_voice = 1'($urandom_range(0, 1));
                    wr_addr = AW'($urandom_range(0, 3));
                    wr_data = {16'($urandom_range(0, 4)), 8'($urandom_range(0, 3))};
                end
                if ($urandom_range(0, 59) == 0 || (loop_en && cyc_r == 100)) stop = 1'b1;
                step("rand");
                start = 1'b0; wr_en = 1'b0; stop = 1'b0;
                cyc_r++;
            end
            if (model_busy()) cmp("rand timeout", cyc_r, -1);
            loop_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
